// File: rtl/chop_clk_monitor.sv
// Per-channel chopper clock monitor: synchronises each CLK/CLKB pair, measures
// the period in master cycles and raises sticky frequency, stuck and phase flags.
module chop_clk_monitor #(
    parameter int NCH       = 16,
    parameter int FMCLK_KHZ = 10000,
    parameter int F1_KHZ    = 32,
    parameter int DF_KHZ    = 4,
    parameter int TOL       = 4,
    parameter int OVL_MAX   = 2,
    parameter int CNT_W     = 12
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             EN,
    input  logic             CLR,
    input  logic [NCH-1:0]   CHOP_CLK,
    input  logic [NCH-1:0]   CHOP_CLKB,
    input  logic [3:0]       RD_SEL,
    output logic [CNT_W-1:0] PERIOD_OUT,
    output logic [NCH-1:0]   VALID,
    output logic [NCH-1:0]   FREQ_ERR,
    output logic [NCH-1:0]   STUCK_ERR,
    output logic [NCH-1:0]   PHASE_ERR,
    output logic             ANY_ERR
);

    localparam int RUN_W = $clog2(OVL_MAX + 2);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic int exp_period(input int k);
        return FMCLK_KHZ / (F1_KHZ + k * DF_KHZ);
    endfunction

    logic [NCH-1:0]   clk_s1, clk_s2, clk_s3;
    logic [NCH-1:0]   clkb_s1, clkb_s2;
    logic [NCH-1:0]   rise, eq, armed;
    logic [NCH-1:0]   freq_bad, stuck_hit, phase_hit;
    logic [CNT_W-1:0] cnt    [NCH];
    logic [CNT_W-1:0] meas   [NCH];
    logic [CNT_W-1:0] period [NCH];
    logic [RUN_W-1:0] run    [NCH];

    // clk_s3 is only the delayed copy used for rising-edge detection.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            clk_s1  <= '0;
            clk_s2  <= '0;
            clk_s3  <= '0;
            clkb_s1 <= '0;
            clkb_s2 <= '0;
        end else begin
            clk_s1  <= CHOP_CLK;
            clk_s2  <= clk_s1;
            clk_s3  <= clk_s2;
            clkb_s1 <= CHOP_CLKB;
            clkb_s2 <= clkb_s1;
        end
    end

    assign rise = clk_s2 & ~clk_s3;
    assign eq   = ~(clk_s2 ^ clkb_s2);

    // meas doubles as the saturating next count, so the stuck flag rises in
    // the same cycle the counter register reaches twice the expected period.
    always_comb begin
        freq_bad  = '0;
        stuck_hit = '0;
        phase_hit = '0;
        for (int k = 0; k < NCH; k++) begin
            meas[k]      = (cnt[k] == CNT_MAX) ? CNT_MAX : cnt[k] + 1'b1;
            freq_bad[k]  = (int'(meas[k]) > exp_period(k) + TOL) ||
                           (int'(meas[k]) < exp_period(k) - TOL);
            stuck_hit[k] = armed[k] && !rise[k] &&
                           (int'(meas[k]) >= 2 * exp_period(k));
            phase_hit[k] = eq[k] && (int'(run[k]) >= OVL_MAX);
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int k = 0; k < NCH; k++) begin
                cnt[k]    <= '0;
                period[k] <= '0;
                run[k]    <= '0;
            end
            armed      <= '0;
            VALID      <= '0;
            FREQ_ERR   <= '0;
            STUCK_ERR  <= '0;
            PHASE_ERR  <= '0;
            ANY_ERR    <= 1'b0;
            PERIOD_OUT <= '0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (!EN || CLR) begin
                    cnt[k]   <= '0;
                    armed[k] <= 1'b0;
                    run[k]   <= '0;
                end else begin
                    cnt[k]   <= rise[k] ? '0 : meas[k];
                    armed[k] <= armed[k] | rise[k];
                    if (!eq[k])
                        run[k] <= '0;
                    else if (run[k] != RUN_W'(OVL_MAX))
                        run[k] <= run[k] + 1'b1;
                end

                // CLR takes priority over any flag that would set this cycle.
                if (CLR) begin
                    VALID[k]     <= 1'b0;
                    FREQ_ERR[k]  <= 1'b0;
                    STUCK_ERR[k] <= 1'b0;
                    PHASE_ERR[k] <= 1'b0;
                end else if (EN) begin
                    if (rise[k] && armed[k]) begin
                        period[k] <= meas[k];
                        VALID[k]  <= 1'b1;
                        if (freq_bad[k])
                            FREQ_ERR[k] <= 1'b1;
                    end
                    if (stuck_hit[k])
                        STUCK_ERR[k] <= 1'b1;
                    if (phase_hit[k])
                        PHASE_ERR[k] <= 1'b1;
                end
            end

            ANY_ERR    <= |{FREQ_ERR, STUCK_ERR, PHASE_ERR};
            PERIOD_OUT <= (int'(RD_SEL) < NCH) ? period[RD_SEL] : '0;
        end
    end

endmodule
